vga_scan_ctl: RTL

//  Scan-out controller for the 320x240x8 graphics memory (gmem) read port. Generates 640x480@60
//  VGA timing from clk via a pixel-enable divider and 2x-upscales each gmem pixel.

---
 rtl/vga_scan_ctl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/vga_scan_ctl.sv
// rtl/vga_scan_ctl.sv - gmem scan-out controller: VGA timing, 2x upscale addressing, read-latency alignment
module vga_scan_ctl #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int CLK_DIV     = 2,
    parameter int SCALE_SHIFT = 1,
    parameter int ADDR_W      = 17,
    parameter int COLOR_W     = 8,
    parameter bit SYNC_POL    = 1'b0,
    parameter int RD_LAT      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [ADDR_W-1:0]  vgactl_addr,
    input  logic [COLOR_W-1:0] vgactl_dat,
    output logic [COLOR_W-1:0] pix,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               frame_start,
    output logic               vblank
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FB_W    = H_ACTIVE >> SCALE_SHIFT;

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [H_W-1:0]    H_LAST     = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]    H_ACT_C    = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0]    HS_BEG     = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0]    HS_END     = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [V_W-1:0]    V_LAST     = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]    V_ACT_C    = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0]    VS_BEG     = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0]    VS_END     = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [V_W-1:0]    SCALE_MASK = V_W'((1 << SCALE_SHIFT) - 1);
    localparam logic [ADDR_W-1:0] FB_W_A     = ADDR_W'(FB_W);

    // Scan position and the framebuffer row base that tracks (v >> SCALE_SHIFT) * FB_W.
    logic [DIV_W-1:0]  div_cnt;
    logic [H_W-1:0]    h_cnt;
    logic [V_W-1:0]    v_cnt;
    logic [ADDR_W-1:0] row_base;

    logic              tick;
    logic              h_wrap;
    logic              v_wrap;
    logic [V_W-1:0]    v_next;
    logic              row_step;

    // Counter-domain decode of the current scan position.
    logic              act_c;
    logic              hs_c;
    logic              vs_c;
    logic              vb_c;
    logic              fs_c;
    logic [ADDR_W-1:0] addr_c;

    // Flags delayed by 1+RD_LAT clocks so they line up with vgactl_dat.
    logic [RD_LAT:0]   act_p;
    logic [RD_LAT:0]   hs_p;
    logic [RD_LAT:0]   vs_p;
    logic [RD_LAT:0]   vb_p;
    logic [RD_LAT:0]   fs_p;

    // Pixel tick and wrap conditions; the row base only steps when the scaled row changes.
    always_comb begin
        tick     = en && (div_cnt == DIV_LAST);
        h_wrap   = (h_cnt == H_LAST);
        v_wrap   = (v_cnt == V_LAST);
        v_next   = v_cnt + 1'b1;
        row_step = ((v_next & SCALE_MASK) == '0) && (v_next < V_ACT_C);
    end

    // Divider, horizontal/vertical counters and incremental row base; en=0 parks everything at (0,0).
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div_cnt  <= '0;
            h_cnt    <= '0;
            v_cnt    <= '0;
            row_base <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                if (h_wrap) begin
                    h_cnt <= '0;
                    if (v_wrap) begin
                        v_cnt    <= '0;
                        row_base <= '0;
                    end else begin
                        v_cnt <= v_next;
                        if (row_step) begin
                            row_base <= row_base + FB_W_A;
                        end
                    end
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    // Timing flags and read address for the current position; all gated by en so a
    // disabled scan produces blank, sync-inactive entries right away.
    always_comb begin
        act_c  = en && (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        hs_c   = en && (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
        vs_c   = en && (v_cnt >= VS_BEG) && (v_cnt <= VS_END);
        vb_c   = en && (v_cnt >= V_ACT_C);
        fs_c   = en && (h_cnt == '0) && (v_cnt == '0) && (div_cnt == '0);
        addr_c = '0;
        if (act_c) begin
            addr_c = row_base + ADDR_W'(h_cnt >> SCALE_SHIFT);
        end
    end

    // Registered gmem read address, zero outside the active area.
    always_ff @(posedge clk) begin
        if (rst) begin
            vgactl_addr <= '0;
        end else begin
            vgactl_addr <= addr_c;
        end
    end

    // Flag delay line; stage 0 is captured alongside vgactl_addr.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_p <= '0;
            hs_p  <= '0;
            vs_p  <= '0;
            vb_p  <= '0;
            fs_p  <= '0;
        end else begin
            act_p <= {act_p[RD_LAT-1:0], act_c};
            hs_p  <= {hs_p[RD_LAT-1:0], hs_c};
            vs_p  <= {vs_p[RD_LAT-1:0], vs_c};
            vb_p  <= {vb_p[RD_LAT-1:0], vb_c};
            fs_p  <= {fs_p[RD_LAT-1:0], fs_c};
        end
    end

    // Output registers: pixel data meets its delayed flags here.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix         <= '0;
            de          <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
            vblank      <= 1'b0;
        end else begin
            pix         <= act_p[RD_LAT] ? vgactl_dat : '0;
            de          <= act_p[RD_LAT];
            hsync       <= hs_p[RD_LAT] ? SYNC_POL : ~SYNC_POL;
            vsync       <= vs_p[RD_LAT] ? SYNC_POL : ~SYNC_POL;
            frame_start <= fs_p[RD_LAT];
            vblank      <= vb_p[RD_LAT];
        end
    end

endmodule
